seg7_scan_driver: RTL and testbench
===================================

Name: seg7_scan_driver

Overview:
- Parametrised multi-digit successor to the single-digit 7-segment decoder.
- Latches an N-digit hex value and time-multiplexes it onto one shared active-low segment bus with per-digit anode enables.
- Inserts a programmable dark gap between digits to suppress ghosting.
- Sits between datapath/display logic and the board's multiplexed 7-segment display.

Parameters:
NUM_DIGITS, 4, number of digits scanned (1..8)
REFRESH_DIV, 50000, clock cycles each digit is lit (>=1)
GAP_CYCLES, 2, dark cycles between digits (0 disables gap)
AN_ACTIVE_LOW, 1, 1: anode enables active-low; 0: active-high

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
load  input  1  latch value/blank_mask this cycle
value  input  4*NUM_DIGITS  hex nibbles; digit i = value[4i+3:4i], digit 0 rightmost
blank_mask  input  NUM_DIGITS  1 = force digit i dark
seg  output  7  segments, active-low, seg[0]=a .. seg[6]=g
an  output  NUM_DIGITS  digit enables, polarity per AN_ACTIVE_LOW
frame_start  output  1  one-cycle pulse when digit 0 begins SHOW

Behaviour:
Reset (rst high at a clk edge):
- Shadow value = 0, shadow mask = 0, digit index = 0, tick counter = 0, state = SHOW.
- Registered outputs: seg = 7'b1111111, all an inactive, frame_start = 0.
- Reset mid-scan aborts immediately; there is no partial-digit completion.
Load:
- load=1 at an edge copies value and blank_mask into shadow registers at that edge.
- The new data appears on seg within 1 cycle if the current digit is in SHOW.
- load during rst is ignored.
- Inputs are not sampled when load=0.
State machine:
- SHOW: the tick counter counts 0..REFRESH_DIV-1.
  - At REFRESH_DIV-1 the counter clears.
  - If GAP_CYCLES > 0, go to GAP.
  - Otherwise advance the digit index and stay in SHOW.
- GAP: the counter counts 0..GAP_CYCLES-1.
  - At GAP_CYCLES-1 the counter clears, the digit index advances, and the state returns to SHOW.
- Digit index wraps NUM_DIGITS-1 -> 0.
- NUM_DIGITS=1: index stays 0; the gap still applies.
Outputs (registered, 1-cycle latency from state/index):
- SHOW, digit i not blanked:
  - an has only bit i active.
  - seg = glyph(shadow nibble i), active-low.
  - Glyph codes (g..a): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
- SHOW, digit i blanked (mask bit set): an bit i is still active and seg = 1111111. This keeps brightness duty constant.
- GAP: all an inactive, seg = 1111111.
- frame_start = 1 for exactly the first output cycle of digit 0 SHOW, including the first SHOW after reset.
Simultaneous events:
- A load on the same edge as a digit advance takes effect for the newly selected digit on that same update.

Optional Feature:
LEADING_ZERO_BLANK_EN:
- Defined: every digit above the most-significant non-zero shadow nibble is additionally treated as blanked.
  - Digit 0 is never auto-blanked, so value 0 shows "0".
  - Auto-blanking is computed from the shadow registers and ORed with the shadow mask.
- Undefined: only blank_mask blanks digits; leading zeros display as "0".

Test Plan:
All tests use NUM_DIGITS=4, REFRESH_DIV=4, GAP_CYCLES=1, AN_ACTIVE_LOW=1.
1. Reset: rst=1 for 3 cycles -> seg=7'b1111111, an=4'b1111, frame_start=0. After release, within 1 cycle an=4'b1110, seg=7'b1000000, frame_start pulses once.
2. Scan timing: load value=16'h1234 -> per digit 4 cycles lit then 1 dark cycle. Sequence: an 1110/seg 0011001 ("4"), 1111, 1101/0110000 ("3"), 1111, 1011/0100100 ("2"), 1111, 0111/1111001 ("1"), 1111, repeat. frame_start period = 20 cycles.
3. Blank mask: value=16'h8888, blank_mask=4'b0100 -> digit 2 window has an=1011 with seg=1111111; the other digits show 0000000.
4. Mid-digit load: during digit 0 SHOW, load value=16'h000F -> seg changes from prior glyph to 0001110 one cycle later; an unchanged.
5. Reset mid-scan: assert rst while digit 2 is lit -> next cycle all dark; after release, digit 0 shows shadow value 0 (seg=1000000).
6. With LEADING_ZERO_BLANK_EN: value=16'h0042 -> digits 3,2 seg=1111111, digit 1 "4", digit 0 "2". value=16'h0000 -> only digit 0 shows 1000000.

Source files
------------

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - multiplexed N-digit hex 7-segment scan driver with dark inter-digit gap
// Optional: define LEADING_ZERO_BLANK_EN to auto-blank digits above the most-significant non-zero nibble.
module seg7_scan_driver #(
  parameter int NUM_DIGITS    = 4,
  parameter int REFRESH_DIV   = 50000,
  parameter int GAP_CYCLES    = 2,
  parameter int AN_ACTIVE_LOW = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load,
  input  logic [4*NUM_DIGITS-1:0]   value,
  input  logic [NUM_DIGITS-1:0]     blank_mask,
  output logic [6:0]                seg,
  output logic [NUM_DIGITS-1:0]     an,
  output logic                      frame_start
);

  localparam int CMAX     = (REFRESH_DIV > GAP_CYCLES) ? REFRESH_DIV : GAP_CYCLES;
  localparam int CW       = $clog2(CMAX + 1);
  localparam int IW       = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
  localparam logic [NUM_DIGITS-1:0] AN_OFF = (AN_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

  typedef enum logic {SHOW, GAP} state_t;

  state_t                    state;
  logic [CW-1:0]             cnt;
  logic [IW-1:0]             idx;
  logic [IW-1:0]             next_idx;
  logic [4*NUM_DIGITS-1:0]   shadow_val;
  logic [NUM_DIGITS-1:0]     shadow_mask;
  logic [NUM_DIGITS-1:0]     blank_vec;
  logic [NUM_DIGITS-1:0]     onehot;
  logic [3:0]                nib;
  logic                      sel_blank;

  function automatic logic [6:0] glyph(input logic [3:0] h);
    case (h)
      4'h0: glyph = 7'b1000000;
      4'h1: glyph = 7'b1111001;
      4'h2: glyph = 7'b0100100;
      4'h3: glyph = 7'b0110000;
      4'h4: glyph = 7'b0011001;
      4'h5: glyph = 7'b0010010;
      4'h6: glyph = 7'b0000010;
      4'h7: glyph = 7'b1111000;
      4'h8: glyph = 7'b0000000;
      4'h9: glyph = 7'b0010000;
      4'hA: glyph = 7'b0001000;
      4'hB: glyph = 7'b0000011;
      4'hC: glyph = 7'b1000110;
      4'hD: glyph = 7'b0100001;
      4'hE: glyph = 7'b0000110;
      default: glyph = 7'b0001110;
    endcase
  endfunction

`ifdef LEADING_ZERO_BLANK_EN
  // Walk down from the top digit; a digit stays dark while every nibble at or above it is zero.
  always_comb begin
    logic any_nz;
    any_nz    = 1'b0;
    blank_vec = shadow_mask;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      any_nz = any_nz | (|shadow_val[4*i +: 4]);
      if (!any_nz) blank_vec[i] = 1'b1;
    end
  end
`else
  always_comb blank_vec = shadow_mask;
`endif

  always_comb begin
    nib       = 4'h0;
    onehot    = '0;
    sel_blank = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IW'(i)) begin
        nib       = shadow_val[4*i +: 4];
        onehot[i] = 1'b1;
        sel_blank = blank_vec[i];
      end
    end
  end

  assign next_idx = (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + IW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= SHOW;
      cnt         <= '0;
      idx         <= '0;
      shadow_val  <= '0;
      shadow_mask <= '0;
      seg         <= 7'b1111111;
      an          <= AN_OFF;
      frame_start <= 1'b0;
    end else begin
      if (load) begin
        shadow_val  <= value;
        shadow_mask <= blank_mask;
      end

      case (state)
        SHOW: begin
          if (cnt == CW'(REFRESH_DIV - 1)) begin
            cnt <= '0;
            if (GAP_CYCLES > 0) state <= GAP;
            else                idx   <= next_idx;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          if (cnt == CW'(GAP_LAST)) begin
            cnt   <= '0;
            idx   <= next_idx;
            state <= SHOW;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
      endcase

      // Outputs trail state/index by one cycle; a blanked digit keeps its anode on for constant duty.
      if (state == SHOW) begin
        an          <= (AN_ACTIVE_LOW != 0) ? ~onehot : onehot;
        seg         <= sel_blank ? 7'b1111111 : glyph(nib);
        frame_start <= (idx == '0) && (cnt == '0);
      end else begin
        an          <= AN_OFF;
        seg         <= 7'b1111111;
        frame_start <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - cycle-accurate vector bench for seg7_scan_driver (4 digits, 4 lit, 1 dark)
module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [15:0] value;
  logic [3:0]  blank_mask;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        frame_start;

  int tests  = 0;
  int failed = 0;

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [6:0] LZSEG = 7'b1111111;
`else
  localparam logic [6:0] LZSEG = 7'b1000000;
`endif

  seg7_scan_driver #(
    .NUM_DIGITS(4), .REFRESH_DIV(4), .GAP_CYCLES(1), .AN_ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .rst(rst), .load(load), .value(value), .blank_mask(blank_mask),
    .seg(seg), .an(an), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        load;
    logic [15:0] value;
    logic [3:0]  mask;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        fs;
  } vec_t;

  vec_t vecs[$];

  function automatic void v(input logic r, input logic l, input logic [15:0] val,
                            input logic [3:0] m, input logic [3:0] a, input logic [6:0] s,
                            input logic f);
    vec_t e;
    e.rst = r; e.load = l; e.value = val; e.mask = m; e.an = a; e.seg = s; e.fs = f;
    vecs.push_back(e);
  endfunction

  function automatic void rep(input int n, input logic [3:0] a, input logic [6:0] s);
    for (int k = 0; k < n; k++) v(1'b0, 1'b0, 16'h0, 4'h0, a, s, 1'b0);
  endfunction

  initial begin
    int gap_wait;
    int period;
    bit seen;

    // Reset, with a load during reset that must be ignored.
    v(1, 0, 16'h0000, 4'h0, 4'hF, 7'h7F, 0);
    v(1, 0, 16'h0000, 4'h0, 4'hF, 7'h7F, 0);
    v(1, 1, 16'h1234, 4'h0, 4'hF, 7'h7F, 0);
    // First SHOW after reset shows shadow 0; load 1234 lands on the same edge.
    v(0, 1, 16'h1234, 4'h0, 4'hE, 7'b1000000, 1);
    rep(3, 4'hE, 7'b0011001);
    rep(1, 4'hF, 7'h7F);
    rep(4, 4'hD, 7'b0110000);
    rep(1, 4'hF, 7'h7F);
    rep(4, 4'hB, 7'b0100100);
    rep(1, 4'hF, 7'h7F);
    rep(4, 4'h7, 7'b1111001);
    rep(1, 4'hF, 7'h7F);
    v(0, 0, 16'h0000, 4'h0, 4'hE, 7'b0011001, 1);
    // Blank mask on digit 2.
    v(0, 1, 16'h8888, 4'h4, 4'hE, 7'b0011001, 0);
    rep(2, 4'hE, 7'b0000000);
    rep(1, 4'hF, 7'h7F);
    rep(4, 4'hD, 7'b0000000);
    rep(1, 4'hF, 7'h7F);
    rep(4, 4'hB, 7'b1111111);
    rep(1, 4'hF, 7'h7F);
    rep(4, 4'h7, 7'b0000000);
    rep(1, 4'hF, 7'h7F);
    v(0, 0, 16'h0000, 4'h0, 4'hE, 7'b0000000, 1);
    // Mid-digit load of 000F.
    v(0, 1, 16'h000F, 4'h0, 4'hE, 7'b0000000, 0);
    rep(2, 4'hE, 7'b0001110);
    rep(1, 4'hF, 7'h7F);
    rep(4, 4'hD, LZSEG);
    rep(1, 4'hF, 7'h7F);
    rep(1, 4'hB, LZSEG);
    // Reset while digit 2 is lit.
    v(1, 0, 16'h0000, 4'h0, 4'hF, 7'h7F, 0);
    v(0, 0, 16'h0000, 4'h0, 4'hE, 7'b1000000, 1);
    rep(3, 4'hE, 7'b1000000);
    // Load on the digit-advance edge feeds the newly selected digit.
    v(0, 1, 16'h00A0, 4'h0, 4'hF, 7'h7F, 0);
    v(0, 0, 16'h0000, 4'h0, 4'hD, 7'b0001000, 0);

    rst = 1'b1; load = 1'b0; value = '0; blank_mask = '0;
    foreach (vecs[i]) begin
      rst        = vecs[i].rst;
      load       = vecs[i].load;
      value      = vecs[i].value;
      blank_mask = vecs[i].mask;
      @(posedge clk);
      #1;
      tests++;
      if (an !== vecs[i].an || seg !== vecs[i].seg || frame_start !== vecs[i].fs) begin
        failed++;
        $display("FAIL vec%0d: an=%b seg=%b fs=%b, required an=%b seg=%b fs=%b",
                 i, an, seg, frame_start, vecs[i].an, vecs[i].seg, vecs[i].fs);
      end
    end
    rst = 1'b0; load = 1'b0;

    // frame_start period: 4 digits x (4 lit + 1 dark) = 20 cycles.
    seen = 1'b0;
    for (gap_wait = 0; gap_wait < 40 && !seen; gap_wait++) begin
      @(posedge clk); #1;
      seen = frame_start;
    end
    tests++;
    if (!seen) begin
      failed++;
      $display("FAIL fs_first: no frame_start within 40 cycles, required a pulse");
    end else begin
      period = 0;
      seen   = 1'b0;
      while (!seen && period < 40) begin
        @(posedge clk); #1;
        period++;
        seen = frame_start;
      end
      tests++;
      if (period != 20) begin
        failed++;
        $display("FAIL fs_period: got %0d cycles, required 20", period);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
